// File: rtl/uart_tx_frame.sv
// Parametrised RS232 frame transmitter: 1..NBYTES bytes per frame, configurable data,
// parity, stop and inter-byte gap bits, clocked from the system clock.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NBYTES       = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NBYTES*DATA_BITS-1:0]   T_data_in,
    input  logic [$clog2(NBYTES+1)-1:0]   tx_len,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TX,
    output logic                          busy,
    output logic                          done
);

    localparam int FRAME_W   = NBYTES * DATA_BITS;
    localparam int LEN_W     = $clog2(NBYTES + 1);
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_MAX_A = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_MAX   = (BIT_MAX_A > GAP_BITS) ? BIT_MAX_A : GAP_BITS;
    localparam int BIT_W     = $clog2(BIT_MAX);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(NBYTES);
    localparam logic              ODD_PAR   = 1'(PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t               state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [LEN_W-1:0]     bytes_left_q;
    logic [DATA_BITS-1:0] byte_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ready_q;

    logic [LEN_W-1:0]     len_eff_d;
    logic                 baud_tick;
    logic                 tx_d;

    always_comb begin
        len_eff_d = tx_len;
        if (tx_len == '0 || tx_len > LEN_MAX) begin
            len_eff_d = LEN_MAX;
        end
        baud_tick = (baud_q == BAUD_LAST);
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_q[0];
            S_PARITY: tx_d = par_q ^ ODD_PAR;
            default:  tx_d = 1'b1;
        endcase
    end

    // TX is registered from the current state, so the line trails the FSM by one clock:
    // the start bit appears one edge after accept and the done cycle is the last stop clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            bytes_left_q <= '0;
            byte_q       <= '0;
            frame_q      <= '0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            tx_q   <= tx_d;
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                baud_q <= '0;
                if (tx_valid) begin
                    byte_q       <= T_data_in[FRAME_W-1 -: DATA_BITS];
                    frame_q      <= T_data_in << DATA_BITS;
                    bytes_left_q <= len_eff_d - LEN_W'(1);
                    bit_q        <= '0;
                    state_q      <= S_START;
                    busy_q       <= 1'b1;
                    ready_q      <= 1'b0;
                end
            end else if (!baud_tick) begin
                baud_q <= baud_q + BAUD_W'(1);
            end else begin
                baud_q <= '0;
                case (state_q)
                    S_START: begin
                        bit_q   <= '0;
                        par_q   <= 1'b0;
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        par_q  <= par_q ^ byte_q[0];
                        byte_q <= byte_q >> 1;
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        bit_q   <= '0;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        if (bit_q != STOP_LAST) begin
                            bit_q <= bit_q + BIT_W'(1);
                        end else if (bytes_left_q == '0) begin
                            bit_q   <= '0;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end else if (GAP_BITS > 0) begin
                            bit_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            bit_q        <= '0;
                            byte_q       <= frame_q[FRAME_W-1 -: DATA_BITS];
                            frame_q      <= frame_q << DATA_BITS;
                            bytes_left_q <= bytes_left_q - LEN_W'(1);
                            state_q      <= S_START;
                        end
                    end
                    S_GAP: begin
                        if (bit_q != GAP_LAST) begin
                            bit_q <= bit_q + BIT_W'(1);
                        end else begin
                            bit_q        <= '0;
                            byte_q       <= frame_q[FRAME_W-1 -: DATA_BITS];
                            frame_q      <= frame_q << DATA_BITS;
                            bytes_left_q <= bytes_left_q - LEN_W'(1);
                            state_q      <= S_START;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready = ready_q;
    assign TX       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
